// File: rtl/tpu_operand_feeder.sv
// Operand-pair FIFO feeding a handshaked multiplier: issues one pair, waits for
// ready/error/timeout, then holds the product until the consumer acknowledges it.
module tpu_operand_feeder #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_a,
  input  logic [7:0]               wr_b,
  output logic                     in_full,
  output logic                     in_empty,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               op_a,
  output logic [7:0]               op_b,
  output logic                     sync,
  input  logic                     tpu_ready,
  input  logic                     tpu_error,
  input  logic [15:0]              tpu_out,
  output logic [15:0]              res_data,
  output logic                     res_valid,
  input  logic                     res_ack,
  output logic                     busy,
  output logic                     ovf_flag,
  output logic                     err_flag,
  output logic                     tmo_flag,
  input  logic                     clr_flags
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

  state_e          state_q;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_a_q [DEPTH];
  logic [7:0]      mem_b_q [DEPTH];
  logic [TW-1:0]   wcnt_q;
  logic [7:0]      op_a_q, op_b_q;
  logic [15:0]     res_data_q;
  logic            sync_q, res_valid_q, ovf_q, err_q, tmo_q;
  logic            full, empty, push_ok, pop, ovf_set, resp_en, err_set, tmo_set;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Full is taken from the registered count, so a same-cycle pop never frees room.
  always_comb begin
    push_ok = wr_en && !full;
    pop     = (state_q == ISSUE);
    ovf_set = wr_en && full;
    resp_en = (state_q == WAIT) && (wcnt_q != '0);
    err_set = resp_en && tpu_error;
    tmo_set = (state_q == WAIT) && !(resp_en && (tpu_ready || tpu_error))
              && (wcnt_q == TW'(TIMEOUT - 1));
    wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + CW'(push_ok) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_a_q[wptr_q] <= wr_a;
      mem_b_q[wptr_q] <= wr_b;
    end
  end

  // Operands are latched on the IDLE->ISSUE edge so they are valid with sync.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sync_q      <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      wcnt_q      <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      sync_q <= 1'b0;
      ovf_q  <= ovf_set | (ovf_q & ~clr_flags);
      err_q  <= err_set | (err_q & ~clr_flags);
      tmo_q  <= tmo_set | (tmo_q & ~clr_flags);
      case (state_q)
        IDLE: begin
          wcnt_q <= '0;
          if (!empty) begin
            state_q <= ISSUE;
            sync_q  <= 1'b1;
            op_a_q  <= mem_a_q[rptr_q];
            op_b_q  <= mem_b_q[rptr_q];
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          wcnt_q  <= '0;
        end
        WAIT: begin
          if (resp_en && tpu_error) begin
            state_q <= IDLE;
          end else if (resp_en && tpu_ready) begin
            res_data_q  <= tpu_out;
            res_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
            state_q <= IDLE;
          end else begin
            wcnt_q <= wcnt_q + TW'(1);
          end
        end
        HOLD: begin
          if (res_ack) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_full    = full;
  assign in_empty   = empty;
  assign fifo_count = count_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign sync       = sync_q;
  assign res_data   = res_data_q;
  assign res_valid  = res_valid_q;
  assign busy       = (state_q != IDLE);
  assign ovf_flag   = ovf_q;
  assign err_flag   = err_q;
  assign tmo_flag   = tmo_q;

endmodule
